// File: rtl/addpkg_div.sv
// Shared types and constants for the single-precision divider and its controller.
package addpkg_div;

    // Divider exception codes
    typedef enum logic [2:0] {
        NONE      = 3'd0,
        INVALID   = 3'd1,
        DIVBYZERO = 3'd2,
        OVERFLOW  = 3'd3,
        UNDERFLOW = 3'd4
    } o_err_t;

    // Controller sequencing states
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LAUNCH    = 3'd1,
        WAIT_BUSY = 3'd2,
        WAIT_DONE = 3'd3,
        DRAIN     = 3'd4,
        DONE      = 3'd5,
        ABORT     = 3'd6
    } fdiv_state_t;

    // Quotient reported when the watchdog aborts an operation
    localparam logic [31:0] CANON_NAN = 32'h7fc00000;

    // RISC-V fflags bit positions
    localparam int FF_NV = 4;
    localparam int FF_DZ = 3;
    localparam int FF_OF = 2;
    localparam int FF_UF = 1;
    localparam int FF_NX = 0;

    // Exception code to fflags contribution; NX is never raised here
    function automatic logic [4:0] err_to_fflags(input o_err_t err);
        logic [4:0] bits;
        bits = 5'b00000;
        case (err)
            INVALID:   bits[FF_NV] = 1'b1;
            DIVBYZERO: bits[FF_DZ] = 1'b1;
            OVERFLOW:  bits[FF_OF] = 1'b1;
            UNDERFLOW: bits[FF_UF] = 1'b1;
            default:   bits = 5'b00000;
        endcase
        return bits;
    endfunction

endpackage

// File: rtl/fdiv_fflags_acc.sv
// Sticky floating-point exception flag accumulator.
module fdiv_fflags_acc
    import addpkg_div::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       set_en,
    input  o_err_t     err,
    output logic [4:0] fflags
);

    logic [4:0] fflags_reg;
    logic [4:0] fflags_next;
    logic [4:0] new_bits;

    // A flag raised in the same cycle as a clear survives the clear
    always_comb begin
        new_bits    = set_en ? err_to_fflags(err) : 5'b00000;
        fflags_next = (clr ? 5'b00000 : fflags_reg) | new_bits;
    end

    // Sticky flag register
    always_ff @(posedge clk) begin
        if (rst) begin
            fflags_reg <= 5'b00000;
        end else begin
            fflags_reg <= fflags_next;
        end
    end

    assign fflags = fflags_reg;

endmodule

// File: rtl/fdiv_seq_ctrl.sv
// Sequencing/writeback controller around the Newton-Raphson FP divider.
module fdiv_seq_ctrl
    import addpkg_div::*;
#(
    parameter int PIPE_DEPTH = 3,
    parameter int START_WAIT = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic [1:0]  req_rm,
    input  logic        flush,
    output logic [31:0] div_a,
    output logic [31:0] div_b,
    output logic [1:0]  div_rm,
    output logic        div_fdiv,
    output logic        div_ena,
    input  logic [31:0] div_s,
    input  logic        div_busy,
    input  o_err_t      div_err,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_data,
    output o_err_t      res_err,
    output logic        res_timeout,
    output logic [4:0]  fflags,
    input  logic        fflags_clr
);

    // Terminal counts: each wait ends on the cycle the counter shows N-1
    localparam logic [6:0] PD_LAST = 7'(PIPE_DEPTH - 1);
    localparam logic [6:0] SW_LAST = 7'(START_WAIT - 1);
    localparam logic [6:0] TO_LAST = 7'(TIMEOUT - 1);

    fdiv_state_t state_reg, state_next;
    logic [6:0]  cnt_reg, cnt_next, cnt_inc;
    logic [31:0] div_a_reg, div_b_reg;
    logic [1:0]  div_rm_reg;
    logic [31:0] res_data_reg;
    o_err_t      res_err_reg;
    logic        res_timeout_reg;
    logic        load_req, load_res, load_to, res_hs;

    // Saturating increment so a stuck state can never wrap the counter
    assign cnt_inc = (cnt_reg == 7'h7f) ? cnt_reg : cnt_reg + 7'd1;

    // Next-state and counter logic; flush outranks every normal transition
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_inc;
        load_req   = 1'b0;
        load_res   = 1'b0;
        load_to    = 1'b0;
        res_hs     = 1'b0;
        case (state_reg)
            IDLE: begin
                cnt_next = 7'd0;
                if (req_valid) begin
                    load_req   = 1'b1;
                    state_next = LAUNCH;
                end
            end
            LAUNCH: begin
                cnt_next   = 7'd0;
                state_next = flush ? ABORT : WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (flush) begin
                    state_next = ABORT;
                    cnt_next   = 7'd0;
                end else if (div_busy) begin
                    state_next = WAIT_DONE;
                    cnt_next   = 7'd0;
                end else if (cnt_reg == SW_LAST) begin
                    // Special operands resolve without the divider iterating
                    state_next = DRAIN;
                    cnt_next   = 7'd0;
                end
            end
            WAIT_DONE: begin
                if (flush) begin
                    state_next = ABORT;
                    cnt_next   = 7'd0;
                end else if (!div_busy) begin
                    state_next = DRAIN;
                    cnt_next   = 7'd0;
                end else if (cnt_reg == TO_LAST) begin
                    load_to    = 1'b1;
                    state_next = DONE;
                end
            end
            DRAIN: begin
                if (flush) begin
                    state_next = ABORT;
                    cnt_next   = 7'd0;
                end else if (cnt_reg == PD_LAST) begin
                    load_res   = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                if (flush) begin
                    state_next = IDLE;
                end else if (res_ready) begin
                    res_hs     = 1'b1;
                    state_next = IDLE;
                end
            end
            ABORT: begin
                // Drain count restarts while the divider is still iterating
                if (div_busy) begin
                    cnt_next = 7'd0;
                end else if (cnt_reg == PD_LAST) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = 7'd0;
            end
        endcase
    end

    // State, counter, operand and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= IDLE;
            cnt_reg         <= 7'd0;
            div_a_reg       <= 32'd0;
            div_b_reg       <= 32'd0;
            div_rm_reg      <= 2'd0;
            res_data_reg    <= 32'd0;
            res_err_reg     <= NONE;
            res_timeout_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (load_req) begin
                div_a_reg  <= req_a;
                div_b_reg  <= req_b;
                div_rm_reg <= req_rm;
            end
            if (load_res) begin
                res_data_reg    <= div_s;
                res_err_reg     <= div_err;
                res_timeout_reg <= 1'b0;
            end else if (load_to) begin
                res_data_reg    <= CANON_NAN;
                res_err_reg     <= INVALID;
                res_timeout_reg <= 1'b1;
            end
        end
    end

    fdiv_fflags_acc u_fflags (
        .clk    (clk),
        .rst    (rst),
        .clr    (fflags_clr),
        .set_en (res_hs),
        .err    (res_err_reg),
        .fflags (fflags)
    );

    assign req_ready   = (state_reg == IDLE);
    assign div_fdiv    = (state_reg == LAUNCH);
    assign div_ena     = (state_reg == LAUNCH) || (state_reg == WAIT_BUSY) ||
                         (state_reg == WAIT_DONE) || (state_reg == DRAIN) ||
                         (state_reg == ABORT);
    assign res_valid   = (state_reg == DONE);
    assign div_a       = div_a_reg;
    assign div_b       = div_b_reg;
    assign div_rm      = div_rm_reg;
    assign res_data    = res_data_reg;
    assign res_err     = res_err_reg;
    assign res_timeout = res_timeout_reg;

endmodule

// File: tb/tb_fdiv_seq_ctrl.sv
// Self-checking bench for fdiv_seq_ctrl with a behavioural divider stub.
module tb_fdiv_seq_ctrl;
    import addpkg_div::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_a, req_b;
    logic [1:0]  req_rm;
    logic        flush;
    logic [31:0] div_a, div_b;
    logic [1:0]  div_rm;
    logic        div_fdiv, div_ena;
    logic [31:0] div_s;
    logic        div_busy;
    o_err_t      div_err;
    logic        res_valid, res_ready;
    logic [31:0] res_data;
    o_err_t      res_err;
    logic        res_timeout;
    logic [4:0]  fflags;
    logic        fflags_clr;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [4:0]  model_ff = 5'b00000;
    int          op_no = 0;

    fdiv_seq_ctrl dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_rm(req_rm), .flush(flush),
        .div_a(div_a), .div_b(div_b), .div_rm(div_rm), .div_fdiv(div_fdiv),
        .div_ena(div_ena), .div_s(div_s), .div_busy(div_busy), .div_err(div_err),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_err(res_err), .res_timeout(res_timeout), .fflags(fflags),
        .fflags_clr(fflags_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference flag contribution of one accepted result
    function automatic logic [4:0] ref_flags(input o_err_t e);
        case (e)
            INVALID:   return 5'b10000;
            DIVBYZERO: return 5'b01000;
            OVERFLOW:  return 5'b00100;
            UNDERFLOW: return 5'b00010;
            default:   return 5'b00000;
        endcase
    endfunction

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
        chk({tag, "_div_a"}, div_a, 32'd0);
        chk({tag, "_div_b"}, div_b, 32'd0);
        chk({tag, "_div_rm"}, 32'(div_rm), 32'd0);
        chk({tag, "_div_fdiv"}, 32'(div_fdiv), 32'd0);
        chk({tag, "_div_ena"}, 32'(div_ena), 32'd0);
        chk({tag, "_res_valid"}, 32'(res_valid), 32'd0);
        chk({tag, "_res_data"}, res_data, 32'd0);
        chk({tag, "_res_err"}, 32'(res_err), 32'(NONE));
        chk({tag, "_res_timeout"}, 32'(res_timeout), 32'd0);
        chk({tag, "_fflags"}, 32'(fflags), 32'd0);
    endtask

    // mode: 0 divider iterates (busy from cycle sd for len cycles),
    //       1 special operand (busy never rises), 2 divider stuck busy from sd.
    // Cycle k counts clock edges after the accepting edge.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] rm,
                          input int mode, input int sd, input int len,
                          input logic [31:0] s, input o_err_t e, input int hold,
                          input logic clr_hs, input int flush_at, input logic flush_done);
        int done_k, idle_k, exp_k, pulses, unstable;
        logic [31:0] exp_data;
        o_err_t      exp_err;
        logic        exp_to;
        done_k = -1; idle_k = -1; pulses = 0; unstable = 0;
        op_no++;
        @(negedge clk);
        req_valid = 1'b1; req_a = a; req_b = b; req_rm = rm;
        div_s = s; div_err = e; div_busy = 1'b0;
        chk("idle_req_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0; req_a = $urandom; req_b = $urandom; req_rm = 2'($urandom);
        chk("launch_fdiv", 32'(div_fdiv), 32'd1);
        chk("launch_ena", 32'(div_ena), 32'd1);
        chk("launch_div_a", div_a, a);
        chk("launch_div_b", div_b, b);
        chk("launch_div_rm", 32'(div_rm), 32'(rm));
        for (int k = 0; k < 300; k++) begin
            if (k > 0 && div_fdiv) pulses++;
            if (div_a !== a || div_b !== b || div_rm !== rm) unstable++;
            if (res_valid) begin done_k = k; break; end
            if (flush_at >= 0 && k > 0 && req_ready) begin idle_k = k; break; end
            div_busy = (mode == 2 && k >= sd) || (mode == 0 && k >= sd && k < sd + len);
            flush = (k == flush_at);
            @(posedge clk);
            @(negedge clk);
        end
        flush = 1'b0; div_busy = 1'b0;
        chk("single_fdiv_pulse", 32'(pulses), 32'd0);
        chk("operands_stable", 32'(unstable), 32'd0);
        if (flush_at >= 0) begin
            chk("abort_no_result", 32'(done_k), 32'hffffffff);
            chk("abort_idle_cycle", 32'(idle_k), 32'(sd + len + 3));
            $display("op %0d a=%h b=%h flushed at k=%0d idle at k=%0d", op_no, a, b, flush_at, idle_k);
            return;
        end
        if (mode == 0)      exp_k = sd + len + 4;
        else if (mode == 1) exp_k = 8;
        else                exp_k = sd + 65;
        chk("done_cycle", 32'(done_k), 32'(exp_k));
        if (done_k < 0) return;
        if (mode == 2) begin exp_data = CANON_NAN; exp_err = INVALID; exp_to = 1'b1; end
        else           begin exp_data = s;         exp_err = e;       exp_to = 1'b0; end
        chk("res_data", res_data, exp_data);
        chk("res_err", 32'(res_err), 32'(exp_err));
        chk("res_timeout", 32'(res_timeout), 32'(exp_to));
        chk("done_ena_low", 32'(div_ena), 32'd0);
        for (int h = 0; h < hold; h++) begin
            req_valid = 1'b1;
            @(posedge clk);
            @(negedge clk);
            if (!(res_valid === 1'b1 && req_ready === 1'b0 && res_data === exp_data &&
                  res_err === exp_err)) unstable++;
        end
        req_valid = 1'b0;
        chk("hold_stable", 32'(unstable), 32'd0);
        if (flush_done) begin
            flush = 1'b1; res_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            flush = 1'b0; res_ready = 1'b0;
            chk("flush_done_valid", 32'(res_valid), 32'd0);
        end else begin
            res_ready = 1'b1; fflags_clr = clr_hs;
            @(posedge clk);
            @(negedge clk);
            res_ready = 1'b0; fflags_clr = 1'b0;
            model_ff = (clr_hs ? 5'b00000 : model_ff) | ref_flags(exp_err);
        end
        chk("post_hs_req_ready", 32'(req_ready), 32'd1);
        chk("fflags", 32'(fflags), 32'(model_ff));
        $display("op %0d a=%h b=%h mode=%0d data=%h err=%0d to=%0d fflags=%b",
                 op_no, a, b, mode, exp_data, exp_err, exp_to, fflags);
    endtask

    initial begin
        int r, mode, sd, len, fa;
        rst = 1'b1; req_valid = 1'b0; req_a = '0; req_b = '0; req_rm = '0;
        flush = 1'b0; div_s = '0; div_busy = 1'b0; div_err = NONE;
        res_ready = 1'b0; fflags_clr = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        // Plain divide 6/2
        run_op(32'h40c00000, 32'h40000000, 2'd0, 0, 1, 10, 32'h40400000, NONE, 0, 1'b0, -1, 1'b0);
        // Divide by zero
        run_op(32'h3f800000, 32'h00000000, 2'd0, 0, 2, 8, 32'h7f800000, DIVBYZERO, 0, 1'b0, -1, 1'b0);
        // Consumer stalls 20 cycles; a pending request must wait
        run_op(32'h41200000, 32'h40a00000, 2'd1, 0, 3, 12, 32'h40000000, NONE, 20, 1'b0, -1, 1'b0);
        // Watchdog abort
        run_op(32'h3f800000, 32'h40400000, 2'd0, 2, 1, 0, 32'h12345678, NONE, 0, 1'b0, -1, 1'b0);
        // Flush 3 cycles into WAIT_DONE
        run_op(32'h40000000, 32'h3f800000, 2'd0, 0, 2, 20, 32'h40000000, NONE, 0, 1'b0, 6, 1'b0);
        // Clear and OVERFLOW in the same handshake cycle
        run_op(32'h7f000000, 32'h00800000, 2'd2, 0, 1, 5, 32'h7f800000, OVERFLOW, 0, 1'b1, -1, 1'b0);
        // Special-operand fast path, then flush of a waiting result
        run_op(32'h7fc00000, 32'h3f800000, 2'd0, 1, 0, 0, 32'h7fc00000, UNDERFLOW, 1, 1'b0, -1, 1'b1);

        for (int i = 0; i < 25; i++) begin
            r = $urandom_range(0, 9);
            mode = (r < 7) ? 0 : ((r < 9) ? 1 : 2);
            sd = $urandom_range(1, 4);
            len = $urandom_range(2, 40);
            fa = (mode == 0 && $urandom_range(0, 7) == 0) ? $urandom_range(sd + 1, sd + len - 1) : -1;
            run_op($urandom, $urandom, 2'($urandom), mode, sd, len, $urandom,
                   o_err_t'($urandom_range(0, 4)), $urandom_range(0, 3),
                   1'($urandom_range(0, 3) == 0), fa, 1'($urandom_range(0, 9) == 0));
        end

        // Reset in the middle of WAIT_DONE
        @(negedge clk);
        req_valid = 1'b1; req_a = 32'h40400000; req_b = 32'h3f800000; req_rm = 2'd3;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        for (int k = 0; k < 6; k++) begin
            div_busy = (k >= 1);
            @(posedge clk);
            @(negedge clk);
        end
        chk("pre_reset_busy_state", 32'(div_ena), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0; div_busy = 1'b0;
        check_reset_outputs("midop_reset");
        $display("op %0d reset during WAIT_DONE", op_no + 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
